aes_round_ctrl: RTL

//  Iterative AES-128 encryption sequencer. Accepts one plaintext/key pair over a valid/ready

---
 rtl/aes_round_ctrl_if.sv | 32 +++
 rtl/aes_round_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl_if.sv
// Host, key-store and round-datapath signals of the AES round controller.
// The controller uses the slave view; the surrounding system uses the master view.
interface aes_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [127:0] in_key;
    logic         key_load;
    logic         key_busy;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         dp_go;
    logic [1:0]   dp_mode;
    logic [127:0] dp_state;
    logic [127:0] dp_key;
    logic [127:0] dp_result;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;

    modport master (
        output in_valid, in_block, in_key, key_busy, rk_data, dp_result, out_ready,
        input  in_ready, key_load, rk_idx, dp_go, dp_mode, dp_state, dp_key,
               out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, in_key, key_busy, rk_data, dp_result, out_ready,
        output in_ready, key_load, rk_idx, dp_go, dp_mode, dp_state, dp_key,
               out_valid, out_block
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: accepts one block, walks the shared round
// datapath through whitening, NR-1 full rounds and a final round, then returns the ciphertext.
module aes_round_ctrl #(
    parameter int NR     = 10,
    parameter int DP_LAT = 1,
    parameter int RK_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    aes_round_ctrl_if.slave bus
);
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        KEYWAIT,
        FETCH,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [127:0]     dp_state_q, dp_state_d;
    logic [127:0]     dp_key_q, dp_key_d;
    logic [127:0]     out_block_q, out_block_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       dp_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            round_q     <= 4'd0;
            cnt_q       <= '0;
            dp_state_q  <= '0;
            dp_key_q    <= '0;
            out_block_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            cnt_q       <= cnt_d;
            dp_state_q  <= dp_state_d;
            dp_key_q    <= dp_key_d;
            out_block_q <= out_block_d;
            out_valid_q <= out_valid_d;
        end
    end

    // cnt_q is shared: it times the round-key read in FETCH and the datapath in WAIT.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        cnt_d       = cnt_q;
        dp_state_d  = dp_state_q;
        dp_key_d    = dp_key_q;
        out_block_d = out_block_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dp_state_d = bus.in_block;
                    round_d    = 4'd0;
                    cnt_d      = '0;
                    state_d    = KEYWAIT;
                end
            end
            KEYWAIT: begin
                if (!bus.key_busy) begin
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (cnt_q == CNT_W'(RK_LAT)) begin
                    dp_key_d = bus.rk_data;
                    cnt_d    = '0;
                    state_d  = ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_W'(DP_LAT - 1)) begin
                    dp_state_d = bus.dp_result;
                    cnt_d      = '0;
                    if (round_q == 4'(NR)) begin
                        out_block_d = bus.dp_result;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dp_mode = 2'd1;
        if (round_q == 4'd0) begin
            dp_mode = 2'd0;
        end else if (round_q == 4'(NR)) begin
            dp_mode = 2'd2;
        end
    end

    // key_load is combinational so the store captures in_key on the accept edge itself.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.key_load  = (state_q == IDLE) && bus.in_valid && rst_n;
    assign bus.rk_idx    = round_q;
    assign bus.dp_go     = (state_q == ISSUE);
    assign bus.dp_mode   = dp_mode;
    assign bus.dp_state  = dp_state_q;
    assign bus.dp_key    = dp_key_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_block = out_block_q;
endmodule
